keypad_time_entry: RTL and testbench



---
 rtl/keypad_time_entry_pkg.sv | 28 ++
 rtl/keypad_time_entry_if.sv | 27 ++
 rtl/keypad_time_entry_key_debounce.sv | 39 +++
 rtl/keypad_time_entry.sv | 99 +++++++++
 tb/tb_keypad_time_entry.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_time_entry_pkg.sv
// Shared types and constants for the keypad MM:SS time-entry path.
// Buffer layout is {min_tens, min_ones, sec_tens, sec_ones}, one BCD digit per nibble.
package keypad_pkg;

   localparam int BCD_W  = 4;
   localparam int TIME_W = 4 * BCD_W;

   // LSB position of each digit inside time_bcd
   localparam int SEC_ONES = 0;
   localparam int SEC_TENS = 4;
   localparam int MIN_ONES = 8;
   localparam int MIN_TENS = 12;

   localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      LOAD,
      LOCKED
   } state_t;

   function automatic logic [BCD_W-1:0] digit_at(input logic [TIME_W-1:0] t, input int lsb);
      return t[lsb +: BCD_W];
   endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Keypad-side inputs and timer-load handshake of keypad_time_entry.
// slave is the entry block; master is whoever drives the keypad and timer side.
interface keypad_time_entry_if;
   import keypad_pkg::*;

   logic [BCD_W-1:0]  bcd;
   logic              key_pressn;
   logic              clearn;
   logic              start;
   logic              busy;
   logic              load_ready;
   logic              load_valid;
   logic [TIME_W-1:0] time_bcd;
   logic [2:0]        digit_count;
   logic              entry_err;

   modport master (
      output bcd, key_pressn, clearn, start, busy, load_ready,
      input  load_valid, time_bcd, digit_count, entry_err
   );

   modport slave (
      input  bcd, key_pressn, clearn, start, busy, load_ready,
      output load_valid, time_bcd, digit_count, entry_err
   );

endinterface

// File: rtl/keypad_time_entry_key_debounce.sv
// Key-down debouncer: one accept pulse per press, needing DEBOUNCE_CYCLES stable
// samples both to accept a press and to re-arm after release.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_pressn,
   output logic accept
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          pressed;
   logic [CW-1:0] cnt;
   logic          differs;
   logic          done;

   // key level disagrees with the debounced state (active-low key)
   assign differs = (pressed == key_pressn);
   assign done    = differs && (cnt == LAST);
   assign accept  = done && !pressed;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pressed <= 1'b0;
         cnt     <= '0;
      end else if (!differs) begin
         cnt <= '0;
      end else if (done) begin
         pressed <= !pressed;
         cnt     <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: debounced digit capture into an MM:SS buffer and timer load.
// Define KEYPAD_SEC_RANGE_CHECK_EN to refuse start when the seconds-tens digit exceeds 5.
module keypad_time_entry
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_DIGITS      = 4
) (
   input  logic                clk,
   input  logic                resetn,
   keypad_time_entry_if.slave  kp
);

   state_t            state_q, state_n;
   logic [TIME_W-1:0] time_q, time_n;
   logic [2:0]        count_q, count_n;
   logic              err_q, err_n;
   logic              accept;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .resetn     (resetn),
      .key_pressn (kp.key_pressn),
      .accept     (accept)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         time_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         time_q  <= time_n;
         count_q <= count_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n = state_q;
      time_n  = time_q;
      count_n = count_q;
      err_n   = 1'b0;
      unique case (state_q)
         IDLE, ENTRY: begin
            // clear beats start beats digit; busy freezes everything but clear
            if (!kp.clearn) begin
               state_n = IDLE;
               time_n  = '0;
               count_n = '0;
            end else if (!kp.busy) begin
               if (kp.start) begin
                  if (state_q == ENTRY && count_q != 3'd0) begin
`ifdef KEYPAD_SEC_RANGE_CHECK_EN
                     if (count_q >= 3'd2 && digit_at(time_q, SEC_TENS) > SEC_TENS_MAX)
                        err_n = 1'b1;
                     else
                        state_n = LOAD;
`else
                     state_n = LOAD;
`endif
                  end
               end else if (accept) begin
                  if (kp.bcd > BCD_MAX || count_q == 3'(MAX_DIGITS)) begin
                     err_n = 1'b1;
                  end else begin
                     time_n  = {digit_at(time_q, MIN_ONES), digit_at(time_q, SEC_TENS),
                                digit_at(time_q, SEC_ONES), kp.bcd};
                     count_n = count_q + 3'd1;
                     state_n = ENTRY;
                  end
               end
            end
         end
         LOAD: begin
            if (kp.load_ready)
               state_n = LOCKED;
         end
         LOCKED: begin
            if (!kp.busy) begin
               state_n = IDLE;
               time_n  = '0;
               count_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign kp.load_valid  = (state_q == LOAD);
   assign kp.time_bcd    = time_q;
   assign kp.digit_count = count_q;
   assign kp.entry_err   = err_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry: directed scenarios plus randomized
// press/clear/start traffic checked against a digit-list model.
module tb_keypad_time_entry;
   import keypad_pkg::*;

   localparam int DB = 4;
`ifdef KEYPAD_SEC_RANGE_CHECK_EN
   localparam bit SEC_CHK = 1'b1;
`else
   localparam bit SEC_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   err_seen = 0;
   int   digs[$];

   keypad_time_entry_if kp();

   keypad_time_entry #(.DEBOUNCE_CYCLES(DB), .MAX_DIGITS(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .kp     (kp)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (resetn && kp.entry_err === 1'b1) err_seen++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic press(input logic [3:0] d, input int hold, input int rel);
      kp.bcd = d; kp.key_pressn = 1'b0; tick(hold);
      kp.key_pressn = 1'b1; tick(rel);
   endtask

   task automatic clear_pulse();
      kp.clearn = 1'b0; tick(1); kp.clearn = 1'b1; tick(1);
   endtask

   // Value the buffer should show: entered digits read as a base-16 number.
   function automatic logic [15:0] model_time();
      int t = 0;
      foreach (digs[i]) t = t * 16 + digs[i];
      return 16'(t);
   endfunction

   task automatic test_reset();
      kp.bcd = '0; kp.key_pressn = 1'b1; kp.clearn = 1'b1; kp.start = 1'b0;
      kp.busy = 1'b0; kp.load_ready = 1'b0;
      resetn = 1'b0; tick(2);
      checks++; if (kp.time_bcd !== 16'h0 || kp.digit_count !== 3'd0) begin failures++;
         $display("FAIL reset_buf got=%h/%0d exp=0000/0", kp.time_bcd, kp.digit_count); end
      checks++; if (kp.load_valid !== 1'b0 || kp.entry_err !== 1'b0) begin failures++;
         $display("FAIL reset_ctl got lv=%b err=%b exp=0/0", kp.load_valid, kp.entry_err); end
      resetn = 1'b1; tick(1);
      checks++; if (kp.time_bcd !== 16'h0 || kp.load_valid !== 1'b0) begin failures++;
         $display("FAIL post_reset got=%h lv=%b exp=0000/0", kp.time_bcd, kp.load_valid); end
   endtask

   task automatic test_digit_entry();
      int e0 = err_seen;
      press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd3, 6, 6); press(4'd0, 6, 6);
      checks++; if (kp.time_bcd !== 16'h1230) begin failures++;
         $display("FAIL entry_time got=%h exp=1230", kp.time_bcd); end
      checks++; if (kp.digit_count !== 3'd4) begin failures++;
         $display("FAIL entry_count got=%0d exp=4", kp.digit_count); end
      checks++; if (err_seen !== e0) begin failures++;
         $display("FAIL entry_noerr got=%0d exp=%0d", err_seen, e0); end
   endtask

   task automatic test_glitch_invalid();
      int e0;
      clear_pulse();
      press(4'd6, 6, 6);
      e0 = err_seen;
      repeat (3) begin
         kp.bcd = 4'd8; kp.key_pressn = 1'b0; tick(DB - 1);
         kp.key_pressn = 1'b1; tick(3);
      end
      checks++; if (kp.time_bcd !== 16'h0006 || kp.digit_count !== 3'd1) begin failures++;
         $display("FAIL glitch_buf got=%h/%0d exp=0006/1", kp.time_bcd, kp.digit_count); end
      press(4'hB, 6, 6);
      checks++; if (err_seen !== e0 + 1) begin failures++;
         $display("FAIL invalid_err got=%0d exp=%0d", err_seen, e0 + 1); end
      checks++; if (kp.time_bcd !== 16'h0006 || kp.digit_count !== 3'd1) begin failures++;
         $display("FAIL invalid_buf got=%h/%0d exp=0006/1", kp.time_bcd, kp.digit_count); end
   endtask

   task automatic test_overflow_clear();
      int e0;
      clear_pulse();
      repeat (4) press(4'd9, 6, 6);
      e0 = err_seen;
      press(4'd5, 6, 6);
      checks++; if (err_seen !== e0 + 1) begin failures++;
         $display("FAIL overflow_err got=%0d exp=%0d", err_seen, e0 + 1); end
      checks++; if (kp.time_bcd !== 16'h9999 || kp.digit_count !== 3'd4) begin failures++;
         $display("FAIL overflow_buf got=%h/%0d exp=9999/4", kp.time_bcd, kp.digit_count); end
      kp.clearn = 1'b0; tick(1); kp.clearn = 1'b1;
      checks++; if (kp.time_bcd !== 16'h0 || kp.digit_count !== 3'd0) begin failures++;
         $display("FAIL clear_buf got=%h/%0d exp=0000/0", kp.time_bcd, kp.digit_count); end
      kp.start = 1'b1; tick(1); kp.start = 1'b0; tick(1);
      checks++; if (kp.load_valid !== 1'b0) begin failures++;
         $display("FAIL idle_start got lv=%b exp=0", kp.load_valid); end
   endtask

   task automatic test_load_handshake();
      press(4'd4, 6, 6); press(4'd5, 6, 6);
      kp.start = 1'b1; tick(1); kp.start = 1'b0;
      checks++; if (kp.load_valid !== 1'b1) begin failures++;
         $display("FAIL load_enter got lv=%b exp=1", kp.load_valid); end
      kp.clearn = 1'b0; kp.bcd = 4'd7; kp.key_pressn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checks++; if (kp.load_valid !== 1'b1 || kp.time_bcd !== 16'h0045) begin failures++;
            $display("FAIL load_hold[%0d] got lv=%b t=%h exp=1/0045", i, kp.load_valid, kp.time_bcd); end
      end
      kp.clearn = 1'b1; kp.key_pressn = 1'b1;
      kp.load_ready = 1'b1; tick(1); kp.load_ready = 1'b0;
      checks++; if (kp.load_valid !== 1'b0) begin failures++;
         $display("FAIL load_drop got lv=%b exp=0", kp.load_valid); end
      tick(DB + 2);
      checks++; if (kp.time_bcd !== 16'h0 || kp.digit_count !== 3'd0) begin failures++;
         $display("FAIL load_exit got=%h/%0d exp=0000/0", kp.time_bcd, kp.digit_count); end
   endtask

   task automatic test_busy_lockout();
      press(4'd2, 6, 6);
      kp.busy = 1'b1;
      // start is ignored while busy in ENTRY
      kp.start = 1'b1; tick(1); kp.start = 1'b0;
      checks++; if (kp.load_valid !== 1'b0) begin failures++;
         $display("FAIL busy_start got lv=%b exp=0", kp.load_valid); end
      press(4'd8, 6, 6);
      checks++; if (kp.time_bcd !== 16'h0002 || kp.digit_count !== 3'd1) begin failures++;
         $display("FAIL busy_entry got=%h/%0d exp=0002/1", kp.time_bcd, kp.digit_count); end
      kp.busy = 1'b0;
      kp.start = 1'b1; tick(1); kp.start = 1'b0;
      kp.busy = 1'b1;
      kp.load_ready = 1'b1; tick(1); kp.load_ready = 1'b0;
      press(4'd7, 6, 6);
      checks++; if (kp.time_bcd !== 16'h0002 || kp.digit_count !== 3'd1) begin failures++;
         $display("FAIL locked_key got=%h/%0d exp=0002/1", kp.time_bcd, kp.digit_count); end
      // key held across the LOCKED exit must not register
      kp.bcd = 4'd8; kp.key_pressn = 1'b0; tick(6);
      kp.busy = 1'b0; tick(6);
      kp.key_pressn = 1'b1; tick(6);
      checks++; if (kp.time_bcd !== 16'h0 || kp.digit_count !== 3'd0) begin failures++;
         $display("FAIL locked_exit got=%h/%0d exp=0000/0", kp.time_bcd, kp.digit_count); end
      press(4'd7, 6, 6);
      checks++; if (kp.time_bcd !== 16'h0007 || kp.digit_count !== 3'd1) begin failures++;
         $display("FAIL after_lock got=%h/%0d exp=0007/1", kp.time_bcd, kp.digit_count); end
      clear_pulse();
   endtask

   task automatic test_sec_range();
      int e0;
      press(4'd1, 6, 6); press(4'd7, 6, 6); press(4'd0, 6, 6);
      e0 = err_seen;
      kp.start = 1'b1; tick(1); kp.start = 1'b0;
      if (SEC_CHK) begin
         checks++; if (kp.load_valid !== 1'b0 || kp.entry_err !== 1'b1) begin failures++;
            $display("FAIL sec_refuse got lv=%b err=%b exp=0/1", kp.load_valid, kp.entry_err); end
         tick(1);
         checks++; if (err_seen !== e0 + 1 || kp.time_bcd !== 16'h0170) begin failures++;
            $display("FAIL sec_refuse_buf got err=%0d t=%h exp=%0d/0170", err_seen, kp.time_bcd, e0 + 1); end
         clear_pulse();
      end else begin
         checks++; if (kp.load_valid !== 1'b1 || kp.time_bcd !== 16'h0170) begin failures++;
            $display("FAIL sec_raw got lv=%b t=%h exp=1/0170", kp.load_valid, kp.time_bcd); end
         kp.load_ready = 1'b1; tick(1); kp.load_ready = 1'b0; tick(1);
         checks++; if (kp.load_valid !== 1'b0 || kp.time_bcd !== 16'h0) begin failures++;
            $display("FAIL sec_raw_done got lv=%b t=%h exp=0/0000", kp.load_valid, kp.time_bcd); end
      end
   endtask

   task automatic test_reset_mid_load();
      press(4'd3, 6, 6);
      kp.start = 1'b1; tick(1); kp.start = 1'b0;
      checks++; if (kp.load_valid !== 1'b1) begin failures++;
         $display("FAIL midload_enter got lv=%b exp=1", kp.load_valid); end
      kp.load_ready = 1'b1; resetn = 1'b0; tick(1); kp.load_ready = 1'b0;
      checks++; if (kp.load_valid !== 1'b0 || kp.time_bcd !== 16'h0) begin failures++;
         $display("FAIL midload_reset got lv=%b t=%h exp=0/0000", kp.load_valid, kp.time_bcd); end
      resetn = 1'b1; tick(2);
      checks++; if (kp.load_valid !== 1'b0 || kp.digit_count !== 3'd0) begin failures++;
         $display("FAIL midload_after got lv=%b n=%0d exp=0/0", kp.load_valid, kp.digit_count); end
   endtask

   task automatic test_random();
      int          e_exp;
      int          op;
      int          n;
      logic [3:0]  d;
      bit          exp_load;
      digs.delete();
      e_exp = err_seen;
      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 9);
         if (op <= 5) begin
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            press(d, $urandom_range(DB, DB + 4), $urandom_range(DB, DB + 4));
            if (d > 9 || digs.size() == 4) e_exp++;
            else digs.push_back(int'(d));
         end else if (op == 6) begin
            kp.bcd = 4'($urandom_range(0, 9));
            kp.key_pressn = 1'b0; tick($urandom_range(1, DB - 1));
            kp.key_pressn = 1'b1; tick($urandom_range(1, DB - 1));
         end else if (op == 7) begin
            clear_pulse();
            digs.delete();
         end else begin
            n = digs.size();
            exp_load = (n >= 1) && !(SEC_CHK && n >= 2 && digs[n-2] > 5);
            if (n >= 1 && !exp_load) e_exp++;
            kp.start = 1'b1; tick(1); kp.start = 1'b0;
            checks++; if (kp.load_valid !== exp_load) begin failures++;
               $display("FAIL rnd_start[%0d] got lv=%b exp=%b", k, kp.load_valid, exp_load); end
            if (exp_load) begin
               tick($urandom_range(0, 3));
               kp.load_ready = 1'b1; tick(1); kp.load_ready = 1'b0;
               digs.delete();
            end
            tick(2);
         end
         checks++; if (kp.time_bcd !== model_time() || kp.digit_count !== 3'(digs.size())) begin failures++;
            $display("FAIL rnd_buf[%0d] got=%h/%0d exp=%h/%0d", k, kp.time_bcd, kp.digit_count,
                     model_time(), digs.size()); end
         checks++; if (err_seen !== e_exp) begin failures++;
            $display("FAIL rnd_err[%0d] got=%0d exp=%0d", k, err_seen, e_exp); end
      end
   endtask

   initial begin
      test_reset();
      test_digit_entry();
      test_glitch_invalid();
      test_overflow_clear();
      test_load_handshake();
      test_busy_lockout();
      test_sec_range();
      test_reset_mid_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
